muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the RV32M extension. It sits beside the single-cycle ALU in the execute stage. It accepts one M-op at a time from EX, runs a 32-iteration shift-add multiply or restoring divide, and returns the result with a one-cycle done pulse. While it works it holds EX stalled, and a pipeline flush kills the operation in flight.

## Interface
Parameters:
- `EARLY_EXIT`, default 1: divide-by-zero and signed overflow (DIV/REM of −2^31 by −1) complete without iterating.
- Data width is `XLEN` (32) from `riscv_pkg`; it is not a local parameter.

Ports:
- `clk`  in  1  — the single clock.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — EX holds a valid M-op. Held high until `done`.
- `op`  in  3  — `muldiv_op_e`, funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `a`  in  XLEN  — rs1 operand, already forwarded.
- `b`  in  XLEN  — rs2 operand, already forwarded.
- `flush`  in  1  — kill the op in flight (branch taken or pipeline flush).
- `busy`  out  1  — high while state ≠ IDLE.
- `done`  out  1  — one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  — registered result; holds its value until the next completion.
- `stall`  out  1  — combinational `start && !done`; feeds `ex_stall`.

## Operation
States (`mdu_state_e`): IDLE, BUSY, DONE.

- **IDLE**
  - When `start && !flush`, latch `op` and the operands.
  - For signed ops, store magnitudes and record the sign flags. MULHSU treats only `a` as signed.
  - If `EARLY_EXIT` is set and the op is a special divide case, compute the result directly and go to DONE.
  - Otherwise clear `count` and go to BUSY.
- **BUSY**
  - One iteration per cycle on the unsigned magnitudes.
  - Multiply uses a 2·XLEN product register with shift-add.
  - Divide uses a restoring algorithm with a XLEN+1-bit partial remainder.
  - When `count==31` at the clock edge, apply the sign fix, load `result`, and go to DONE.
- **DONE**
  - `done = !flush`. Always go to IDLE next.
  - A `start` that is still high in the following IDLE cycle is a new op; EX has advanced by then.
- **flush** in any state: the next state is IDLE and `result` is not updated.
- **Result selection**
  - MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
  - Negate the full 64-bit product if the operand signs differ.
  - Quotient sign is sign(a) XOR sign(b). Remainder takes the sign of the dividend.
- **Special cases** (the same results apply when `EARLY_EXIT`=0, produced after iterating):
  - DIV or DIVU by 0 gives 0xFFFFFFFF.
  - REM or REMU by 0 gives `a`.
  - DIV overflow gives 0x80000000.
  - REM overflow gives 0.
- MUL by 0 has no early exit.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `result`=0, `count`=0. Reset overrides `start` and `flush` in the same cycle.
- **Normal op:** `start` is sampled in cycle 0, BUSY covers cycles 1–32, and `done` asserts in cycle 33. Latency is 33 cycles; throughput is one op per 34 cycles.
- **Early exit:** `done` asserts in cycle 1.
- **`stall`** is high in cycles 0 through 32 and low in the done cycle, so EX advances on the `done` edge.
- **Flush with start:** `flush` and `start` together in IDLE means the op is not accepted.
- **Flush in DONE:** `done` is suppressed and `result` keeps its old value.
- **`count`** is 5 bits and does not wrap past 31 because the state leaves BUSY at 31.
- **Reset mid-op:** returns to IDLE on the next edge with no `done`.

## Structure
- Add `muldiv_op_e` and `mdu_state_e` to `riscv_pkg`, along with the constants `MDU_ITERS=32` and `DIV_OVF_RESULT=32'h8000_0000`.
- Single module with no sub-module. The shared iteration datapath, the sign-fix logic and the FSM fit together.
- The instance lives inside `ex_stage`. Its `stall` is ORed into `ex_stall`, and `result` is muxed into `alu_result` when the op is an M-op.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB with `done` in cycle 33; `stall` is high in cycles 0–32.
- MULH, MULHU and MULHSU with a=b=0x80000000 → 0x40000000, 0x40000000 and 0xC0000000 respectively.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Early exit (`EARLY_EXIT`=1):
  - DIVU 5/0 → 0xFFFFFFFF in cycle 1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - Repeat with `EARLY_EXIT`=0: same values, `done` in cycle 33.
- `flush` in BUSY at `count`=10 → IDLE on the next cycle, no `done` pulse, `result` unchanged. A new MUL issued immediately afterwards completes correctly 33 cycles later.
- `reset` asserted in BUSY → all outputs return to their reset values on the next edge. Back-to-back ops with `start` held across `done` → the second op is accepted in the cycle after `done`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: data width plus the multiply/divide sequencer types.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // Iterations per multiply/divide: one result bit per cycle.
    localparam int unsigned MDU_ITERS = 32;

    // DIV result for the signed overflow case (-2^31 / -1).
    localparam logic [XLEN-1:0] DIV_OVF_RESULT = 32'h8000_0000;

    // funct3 encoding of the M-extension ops.
    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mdu_state_e;

    // Divide-class ops all have funct3[2] set.
    function automatic logic op_is_div(muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Shift-add multiply and restoring
// divide share one accumulator pair ({acc_hi, acc_lo}); signs are stripped on
// entry and re-applied on the final iteration.
module muldiv_seq
    import riscv_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    mdu_state_e      state_q;
    muldiv_op_e      op_q;
    logic [XLEN-1:0] b_q;       // magnitude of b
    logic [XLEN-1:0] acc_hi_q;  // product high half / partial remainder
    logic [XLEN-1:0] acc_lo_q;  // product low half / dividend-quotient
    logic            neg_q;     // negate the selected result at the end
    logic [4:0]      count_q;
    logic [XLEN-1:0] pend_q;    // result waiting in DONE
    logic [XLEN-1:0] result_q;  // last committed result

    // Entry decode of the incoming op.
    muldiv_op_e      op_in;
    logic            sign_a, sign_b, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] early_res;

    // Iteration datapath.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ok;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    // Sign extraction, magnitudes and the early-exit special cases.
    always_comb begin
        op_in  = muldiv_op_e'(op);
        sign_a = a[XLEN-1] && (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem});
        sign_b = b[XLEN-1] && (op_in inside {OpMulh, OpDiv, OpRem});
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;

        neg_in = 1'b0;
        case (op_in)
            OpMulh, OpMulhsu: neg_in = sign_a ^ sign_b;
            // Divide by zero must give all ones, never a negated quotient.
            OpDiv:            neg_in = (sign_a ^ sign_b) && (b != '0);
            OpRem:            neg_in = sign_a;
            default:          neg_in = 1'b0;
        endcase

        div_zero = op_is_div(op_in) && (b == '0);
        div_ovf  = (op_in inside {OpDiv, OpRem}) && (a == DIV_OVF_RESULT) && (b == '1);
        special  = div_zero || div_ovf;

        early_res = '0;
        if (div_zero) begin
            early_res = (op_in inside {OpRem, OpRemu}) ? a : '1;
        end else if (div_ovf) begin
            early_res = (op_in == OpDiv) ? DIV_OVF_RESULT : '0;
        end
    end

    // One multiply or divide step, plus sign fix and result select for the last step.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ok    = div_shift >= {1'b0, b_q};

        if (op_is_div(op_q)) begin
            step_hi = div_ok ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], div_ok};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end

        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_q ? -step_hi : step_hi;

        case (op_q)
            OpMul:                     final_res = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: final_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             final_res = quo_fix;
            default:                   final_res = rem_fix;
        endcase
    end

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            pend_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && !flush) begin
                        op_q     <= op_in;
                        b_q      <= mag_b;
                        neg_q    <= neg_in;
                        acc_hi_q <= '0;
                        acc_lo_q <= mag_a;
                        count_q  <= '0;
                        if (EARLY_EXIT && special) begin
                            pend_q  <= early_res;
                            state_q <= StDone;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        acc_hi_q <= step_hi;
                        acc_lo_q <= step_lo;
                        if (count_q == 5'(MDU_ITERS - 1)) begin
                            pend_q  <= final_res;
                            state_q <= StDone;
                        end else begin
                            count_q <= count_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    // A flushed completion is dropped and never becomes visible.
                    if (!flush) begin
                        result_q <= pend_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status outputs; result shows the pending value only in an unflushed done cycle.
    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone) && !flush;
        result = done ? pend_q : result_q;
        stall  = start && !done;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: one instance with early exit, one without.
module tb_muldiv_seq;

    logic        clk;
    logic        rst     [2];
    logic        start_s [2];
    logic        flush_s [2];
    logic [2:0]  op_s    [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        stall_s [2];
    logic [31:0] res_s   [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res [2];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat_ee;
    } vec_t;

    vec_t vecs [14];

    muldiv_seq #(.EARLY_EXIT(1'b1)) u_dut_ee (
        .clk    (clk),
        .reset  (rst[0]),
        .start  (start_s[0]),
        .op     (op_s[0]),
        .a      (a_s[0]),
        .b      (b_s[0]),
        .flush  (flush_s[0]),
        .busy   (busy_s[0]),
        .done   (done_s[0]),
        .result (res_s[0]),
        .stall  (stall_s[0])
    );

    muldiv_seq #(.EARLY_EXIT(1'b0)) u_dut_ne (
        .clk    (clk),
        .reset  (rst[1]),
        .start  (start_s[1]),
        .op     (op_s[1]),
        .a      (a_s[1]),
        .b      (b_s[1]),
        .flush  (flush_s[1]),
        .busy   (busy_s[1]),
        .done   (done_s[1]),
        .result (res_s[1]),
        .stall  (stall_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Behavioural RV32M model using wide integer arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        longint      sx, sy, ux, uy, p;
        logic [63:0] pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy;
                return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy;
                return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input int d, input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
        bit sgn_ovf;
        sgn_ovf = !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
        if (d == 0 && o[2] && (y == 0 || sgn_ovf)) return 1;
        return 33;
    endfunction

    // Issue one op with start held; cycle 0 is the cycle start is first sampled.
    task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                          input bit hold, input string nm);
        int          cyc;
        bit          seen;
        bit          stall_ok;
        logic        busy0;
        logic [31:0] got;
        op_s[d]    = o;
        a_s[d]     = x;
        b_s[d]     = y;
        start_s[d] = 1'b1;
        cyc        = 0;
        seen       = 1'b0;
        stall_ok   = 1'b1;
        busy0      = 1'bx;
        got        = 'x;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (cyc == 0) busy0 = busy_s[d];
            if (done_s[d]) begin
                seen = 1'b1;
                got  = res_s[d];
                if (stall_s[d] !== 1'b0) stall_ok = 1'b0;
            end else begin
                if (stall_s[d] !== 1'b1) stall_ok = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) start_s[d] = 1'b0;
        chk({nm, "_idle_at_issue"}, {31'b0, busy0}, 32'd0);
        chk({nm, "_result"}, got, exp);
        chk({nm, "_latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
        chk({nm, "_stall"}, {31'b0, stall_ok}, 32'd1);
        if (seen) last_res[d] = exp;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[3]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,          32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        vecs[12] = '{3'd6, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 1};
        vecs[13] = '{3'd0, 32'h1234_5678, 32'd0,          32'h0,         33};

        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            start_s[d]  = 1'b0;
            flush_s[d]  = 1'b0;
            op_s[d]     = 3'd0;
            a_s[d]      = '0;
            b_s[d]      = '0;
            last_res[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_busy_d%0d", d), {31'b0, busy_s[d]}, 32'd0);
            chk($sformatf("reset_done_d%0d", d), {31'b0, done_s[d]}, 32'd0);
            chk($sformatf("reset_result_d%0d", d), res_s[d], 32'd0);
            chk($sformatf("reset_stall_d%0d", d), {31'b0, stall_s[d]}, 32'd0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 2; d++) begin
                run_op(d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                       (d == 0) ? vecs[i].lat_ee : 33, 1'b0, $sformatf("vec%0d_d%0d", i, d));
            end
        end

        // Flush in BUSY when count reaches 10, then an immediate new MUL.
        op_s[0] = 3'd0; a_s[0] = 32'd3; b_s[0] = 32'd5; start_s[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        flush_s[0] = 1'b1;
        start_s[0] = 1'b0;
        @(negedge clk);
        chk("flush_busy_still_busy", {31'b0, busy_s[0]}, 32'd1);
        chk("flush_busy_no_done", {31'b0, done_s[0]}, 32'd0);
        @(posedge clk);
        #1;
        flush_s[0] = 1'b0;
        @(negedge clk);
        chk("flush_busy_idle", {31'b0, busy_s[0]}, 32'd0);
        chk("flush_busy_result_kept", res_s[0], last_res[0]);
        @(posedge clk);
        #1;
        run_op(0, 3'd0, 32'h1234_5678, 32'd9, ref_mdu(3'd0, 32'h1234_5678, 32'd9), 33, 1'b0,
               "post_flush_mul");

        // Flush together with start in IDLE: op is not accepted.
        op_s[0] = 3'd5; a_s[0] = 32'd5; b_s[0] = 32'd0;
        start_s[0] = 1'b1; flush_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0; flush_s[0] = 1'b0;
        @(negedge clk);
        chk("flush_start_not_accepted", {31'b0, busy_s[0]}, 32'd0);
        chk("flush_start_no_done", {31'b0, done_s[0]}, 32'd0);
        @(posedge clk);
        #1;

        // Flush in DONE of an early-exit op: done suppressed, result unchanged.
        op_s[0] = 3'd5; a_s[0] = 32'd5; b_s[0] = 32'd0; start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        flush_s[0] = 1'b1;
        @(negedge clk);
        chk("flush_done_busy", {31'b0, busy_s[0]}, 32'd1);
        chk("flush_done_no_done", {31'b0, done_s[0]}, 32'd0);
        chk("flush_done_result_in_cycle", res_s[0], last_res[0]);
        @(posedge clk);
        #1;
        flush_s[0] = 1'b0;
        start_s[0] = 1'b0;
        @(negedge clk);
        chk("flush_done_idle", {31'b0, busy_s[0]}, 32'd0);
        chk("flush_done_result_kept", res_s[0], last_res[0]);
        @(posedge clk);
        #1;

        // Reset in BUSY on the non-early-exit instance.
        op_s[1] = 3'd5; a_s[1] = 32'd1000; b_s[1] = 32'd3; start_s[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        start_s[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("midop_reset_busy", {31'b0, busy_s[1]}, 32'd0);
        chk("midop_reset_done", {31'b0, done_s[1]}, 32'd0);
        chk("midop_reset_result", res_s[1], 32'd0);
        chk("midop_reset_stall", {31'b0, stall_s[1]}, 32'd0);
        last_res[1] = '0;
        @(posedge clk);
        #1;

        // Back-to-back with start held across done.
        run_op(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33, 1'b1, "b2b_first");
        run_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0, "b2b_second");

        // Randomized ops against the behavioural model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 20; i++) begin
                o = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0:       x = 32'h0;
                    1:       x = 32'h8000_0000;
                    2:       x = 32'hFFFF_FFFF;
                    default: x = $urandom;
                endcase
                case ($urandom_range(0, 5))
                    0:       y = 32'h0;
                    1:       y = 32'hFFFF_FFFF;
                    2:       y = 32'($urandom_range(1, 9));
                    default: y = $urandom;
                endcase
                run_op(d, o, x, y, ref_mdu(o, x, y), ref_lat(d, o, x, y), 1'b0,
                       $sformatf("rand%0d_d%0d_op%0d", i, d, o));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
